// File: rtl/approx_mult_pkg.sv
// Shared definitions for the leading-one approximate multiplier controller:
// FSM state encoding, default sizing constants and width helpers.
// Optional feature macro: APPROX_ZERO_SKIP_EN (adds the CLEAR state).
package approx_mult_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int KEEP_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ARM      = 4'd1,
    ST_LOAD_A   = 4'd2,
    ST_LOAD_B   = 4'd3,
    ST_NORM_A   = 4'd4,
    ST_NORM_B   = 4'd5,
    ST_MULT     = 4'd6,
    ST_LOAD_RES = 4'd7,
    ST_SCALE    = 4'd8,
    ST_SAVE     = 4'd9,
`ifdef APPROX_ZERO_SKIP_EN
    ST_DONE     = 4'd10,
    ST_CLEAR    = 4'd11
`else
    ST_DONE     = 4'd10
`endif
  } state_e;

  // Maximum number of normalising shifts per operand.
  function automatic int maxs(input int data_w, input int keep_w);
    return data_w - keep_w;
  endfunction

  // Bits needed to hold the values 0..n, never less than one.
  function automatic int width_of(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to address depth entries, never less than one.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/approx_norm_cnt.sv
// Normalisation shift counter: clears on request, counts up on inc and
// stops at MAXS, flagging saturation so the FSM stops shifting.
module approx_norm_cnt #(
  parameter int MAXS = 8,
  parameter int CW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          sat
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign sat = (cnt_q == CW'(MAXS));
  assign cnt = cnt_q;

  // Next count: clear wins over increment; never counts past MAXS.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/approx_mult_ctrl.sv
// Control unit for the truncated (leading-one) approximate multiplier.
// Walks DEPTH operand pairs through load, normalise, multiply, rescale and
// write-back, keeping all counters internally.
// Optional feature macro: APPROX_ZERO_SKIP_EN (zero operand early exit).
//
// Handshake: start is a level request. It moves IDLE to ARM; the run only
// begins once start is seen low in ARM. busy is high from ARM until the
// last SAVE; done is a single-cycle pulse one cycle after the last write.
module approx_mult_ctrl
  import approx_mult_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int KEEP_W = KEEP_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = $clog2(2 * DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      a_msb,
  input  logic                      b_msb,
  input  logic                      a_zero,
  input  logic                      b_zero,
  output logic [AW-1:0]             rd_addr,
  output logic [idx_w(DEPTH)-1:0]   out_addr,
  output logic                      load_en_A,
  output logic                      load_en_B,
  output logic                      shift_en_A,
  output logic                      shift_en_B,
  output logic                      mult_en,
  output logic                      load_en_result,
  output logic                      shift_en_result,
  output logic                      clear_result,
  output logic                      write_enable,
  output logic                      busy,
  output logic                      done
);

  localparam int MAXS = maxs(DATA_W, KEEP_W);
  localparam int CW   = width_of(MAXS);
  localparam int RW   = width_of(2 * MAXS);
  localparam int IW   = idx_w(DEPTH);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [RW-1:0] rs_q, rs_d;

  logic          cnt_clr;
  logic          inc_a, inc_b;
  logic [CW-1:0] cnt_a, cnt_b;
  logic          sat_a, sat_b;
  logic          skip_zero;

`ifdef APPROX_ZERO_SKIP_EN
  // Only the first NORM_A cycle (nothing shifted yet) may take the exit.
  assign skip_zero = (cnt_a == '0) && (a_zero || b_zero);
`else
  logic zero_flags_unused;
  assign zero_flags_unused = a_zero | b_zero;
  assign skip_zero = 1'b0;
`endif

  approx_norm_cnt #(.MAXS(MAXS), .CW(CW)) u_cnt_a (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (inc_a),
    .cnt (cnt_a),
    .sat (sat_a)
  );

  approx_norm_cnt #(.MAXS(MAXS), .CW(CW)) u_cnt_b (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (inc_b),
    .cnt (cnt_b),
    .sat (sat_b)
  );

  // Next-state, counter updates and output decode for the sequencer.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    rs_d            = rs_q;
    cnt_clr         = 1'b0;
    inc_a           = 1'b0;
    inc_b           = 1'b0;
    rd_addr         = '0;
    out_addr        = '0;
    load_en_A       = 1'b0;
    load_en_B       = 1'b0;
    shift_en_A      = 1'b0;
    shift_en_B      = 1'b0;
    mult_en         = 1'b0;
    load_en_result  = 1'b0;
    shift_en_result = 1'b0;
    clear_result    = 1'b0;
    write_enable    = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_ARM;
      end
      ST_ARM: begin
        cnt_clr = 1'b1;
        idx_d   = '0;
        if (!start) state_d = ST_LOAD_A;
      end
      ST_LOAD_A: begin
        rd_addr   = AW'({idx_q, 1'b0});
        load_en_A = 1'b1;
        state_d   = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        rd_addr   = AW'({idx_q, 1'b1});
        load_en_B = 1'b1;
        cnt_clr   = 1'b1;
        state_d   = ST_NORM_A;
      end
      ST_NORM_A: begin
        if (skip_zero) begin
`ifdef APPROX_ZERO_SKIP_EN
          state_d = ST_CLEAR;
`endif
        end else if (a_msb || sat_a) begin
          state_d = ST_NORM_B;
        end else begin
          shift_en_A = 1'b1;
          inc_a      = 1'b1;
        end
      end
      ST_NORM_B: begin
        if (b_msb || sat_b) begin
          // Remaining rescale shifts: whatever normalisation did not use.
          rs_d    = RW'(2 * MAXS) - RW'(cnt_a) - RW'(cnt_b);
          state_d = ST_MULT;
        end else begin
          shift_en_B = 1'b1;
          inc_b      = 1'b1;
        end
      end
      ST_MULT: begin
        mult_en = 1'b1;
        state_d = ST_LOAD_RES;
      end
      ST_LOAD_RES: begin
        load_en_result = 1'b1;
        state_d        = ST_SCALE;
      end
      ST_SCALE: begin
        if (rs_q == '0) begin
          state_d = ST_SAVE;
        end else begin
          shift_en_result = 1'b1;
          rs_d            = rs_q - RW'(1);
        end
      end
      ST_SAVE: begin
        write_enable = 1'b1;
        out_addr     = idx_q;
        if (idx_q == IW'(DEPTH - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ST_LOAD_A;
        end
      end
`ifdef APPROX_ZERO_SKIP_EN
      ST_CLEAR: begin
        clear_result = 1'b1;
        state_d      = ST_SAVE;
      end
`endif
      ST_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pair index and rescale counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rs_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rs_q    <= rs_d;
    end
  end

endmodule

// File: tb/tb_approx_mult_ctrl.sv
// Bench for approx_mult_ctrl: a 16/8-bit, 4-pair instance with a simple
// operand-register model, plus an 8/8-bit, 2-pair instance (no shifting).
`timescale 1ns/1ps
module tb_approx_mult_ctrl;

  localparam int DW   = 16;
  localparam int KW   = 8;
  localparam int DEP  = 4;
  localparam int MAXS = DW - KW;
  localparam int AW   = $clog2(2 * DEP);
  localparam int OW   = $clog2(DEP);
`ifdef APPROX_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct {int addr; int sa; int sb; int sr; int clr; int cyc;} rec_t;
  typedef struct {logic [15:0] a; logic [15:0] b; int sa; int sb; int sr; int clr; int cyc;} vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT 1 (16/8, DEPTH 4) ----------------
  logic start = 1'b0;
  logic a_msb, b_msb, a_zero, b_zero;
  logic [AW-1:0] rd_addr;
  logic [OW-1:0] out_addr;
  logic load_en_A, load_en_B, shift_en_A, shift_en_B, mult_en, load_en_result;
  logic shift_en_result, clear_result, write_enable, busy, done;

  approx_mult_ctrl #(.DATA_W(DW), .KEEP_W(KW), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_msb(a_msb), .b_msb(b_msb), .a_zero(a_zero), .b_zero(b_zero),
    .rd_addr(rd_addr), .out_addr(out_addr),
    .load_en_A(load_en_A), .load_en_B(load_en_B),
    .shift_en_A(shift_en_A), .shift_en_B(shift_en_B),
    .mult_en(mult_en), .load_en_result(load_en_result),
    .shift_en_result(shift_en_result), .clear_result(clear_result),
    .write_enable(write_enable), .busy(busy), .done(done)
  );

  logic [15:0] mem [2*DEP];
  logic [15:0] a_reg = '0, b_reg = '0;
  always @(posedge clk) begin
    if (load_en_A) a_reg <= mem[rd_addr];
    else if (shift_en_A) a_reg <= a_reg << 1;
    if (load_en_B) b_reg <= mem[rd_addr];
    else if (shift_en_B) b_reg <= b_reg << 1;
  end
  assign a_msb  = a_reg[15];
  assign b_msb  = b_reg[15];
  assign a_zero = (a_reg == '0);
  assign b_zero = (b_reg == '0);

  // ---------------- DUT 2 (8/8, DEPTH 2) ----------------
  logic start2 = 1'b0;
  logic a2_msb, b2_msb, a2_zero, b2_zero;
  logic [1:0] rd_addr2;
  logic [0:0] out_addr2;
  logic le_a2, le_b2, sh_a2, sh_b2, mult2, le_r2, sh_r2, clr2, we2, busy2, done2;

  approx_mult_ctrl #(.DATA_W(8), .KEEP_W(8), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .a_msb(a2_msb), .b_msb(b2_msb), .a_zero(a2_zero), .b_zero(b2_zero),
    .rd_addr(rd_addr2), .out_addr(out_addr2),
    .load_en_A(le_a2), .load_en_B(le_b2), .shift_en_A(sh_a2), .shift_en_B(sh_b2),
    .mult_en(mult2), .load_en_result(le_r2), .shift_en_result(sh_r2),
    .clear_result(clr2), .write_enable(we2), .busy(busy2), .done(done2)
  );

  logic [7:0] mem2 [4];
  logic [7:0] a2_reg = '0, b2_reg = '0;
  always @(posedge clk) begin
    if (le_a2) a2_reg <= mem2[rd_addr2];
    else if (sh_a2) a2_reg <= a2_reg << 1;
    if (le_b2) b2_reg <= mem2[rd_addr2];
    else if (sh_b2) b2_reg <= b2_reg << 1;
  end
  assign a2_msb  = a2_reg[7];
  assign b2_msb  = b2_reg[7];
  assign a2_zero = (a2_reg == '0);
  assign b2_zero = (b2_reg == '0);

  // ---------------- monitors (sample on falling edge) ----------------
  int m_now = 0, m_cyc = 0, m_sa = 0, m_sb = 0, m_sr = 0, m_clr = 0;
  int done_cnt = 0, done_at = 0, last_wr = 0, load_cnt = 0;
  rec_t obs_q[$];
  rec_t exp_q[$];
  always @(negedge clk) begin
    m_now <= m_now + 1;
    if (load_en_A) begin
      m_cyc <= 1; m_sa <= 0; m_sb <= 0; m_sr <= 0; m_clr <= 0;
      load_cnt <= load_cnt + 1;
    end else begin
      m_cyc <= m_cyc + 1;
      m_sa  <= m_sa + int'(shift_en_A);
      m_sb  <= m_sb + int'(shift_en_B);
      m_sr  <= m_sr + int'(shift_en_result);
      m_clr <= m_clr + int'(clear_result);
    end
    if (write_enable) begin
      obs_q.push_back('{addr: int'(out_addr), sa: m_sa, sb: m_sb, sr: m_sr,
                        clr: m_clr, cyc: m_cyc + 1});
      last_wr <= m_now;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_at  <= m_now;
    end
  end

  int m2_cyc = 0, sh2_cnt = 0, done2_cnt = 0;
  int obs2_cyc[$];
  int obs2_addr[$];
  always @(negedge clk) begin
    m2_cyc  <= le_a2 ? 1 : m2_cyc + 1;
    sh2_cnt <= sh2_cnt + int'(sh_a2) + int'(sh_b2) + int'(sh_r2);
    if (we2) begin
      obs2_cyc.push_back(m2_cyc + 1);
      obs2_addr.push_back(int'(out_addr2));
    end
    if (done2) done2_cnt <= done2_cnt + 1;
  end

  // ---------------- scoreboard helpers ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Leading zeros of x, limited to the normalisation budget.
  function automatic int lz_cap(input logic [15:0] x);
    int lz;
    lz = DW - $clog2(int'(x) + 1);
    return (lz > MAXS) ? MAXS : lz;
  endfunction

  // Reference behaviour of one pair.
  function automatic rec_t model(input int idx, input logic [15:0] a, input logic [15:0] b);
    rec_t r;
    r.addr = idx;
    if (SKIP && (a == 16'h0 || b == 16'h0)) begin
      r.sa = 0; r.sb = 0; r.sr = 0; r.clr = 1; r.cyc = 5;
    end else begin
      r.sa  = lz_cap(a);
      r.sb  = lz_cap(b);
      r.sr  = 2 * MAXS - r.sa - r.sb;
      r.clr = 0;
      r.cyc = 8 + 2 * MAXS;
    end
    return r;
  endfunction

  function automatic int outs1();
    return int'({rd_addr, out_addr, load_en_A, load_en_B, shift_en_A, shift_en_B,
                 mult_en, load_en_result, shift_en_result, clear_result,
                 write_enable, busy, done});
  endfunction

  function automatic int outs2();
    return int'({rd_addr2, out_addr2, le_a2, le_b2, sh_a2, sh_b2, mult2, le_r2,
                 sh_r2, clr2, we2, busy2, done2});
  endfunction

  // One full run of DUT 1; exp_q must already hold DEP expected records.
  task automatic run1(input int hold);
    int base, d0, l0, t;
    rec_t o, e;
    base = obs_q.size();
    d0   = done_cnt;
    l0   = load_cnt;
    start = 1'b1;
    repeat (hold) tick();
    chk("arm_busy", int'(busy), 1);
    chk("arm_no_load_while_start", load_cnt - l0, 0);
    start = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      tick();
      t++;
    end
    chk("done_seen", int'(done_cnt != d0), 1);
    chk("done_after_last_write", done_at - last_wr, 1);
    tick();
    chk("done_single_pulse", done_cnt - d0, 1);
    chk("busy_low_after_done", int'(busy), 0);
    chk("write_count", obs_q.size() - base, DEP);
    for (int i = 0; i < DEP; i++) begin
      e = exp_q.pop_front();
      if (base + i < obs_q.size()) begin
        o = obs_q[base + i];
        chk($sformatf("pair%0d_addr", i), o.addr, e.addr);
        chk($sformatf("pair%0d_shift_a", i), o.sa, e.sa);
        chk($sformatf("pair%0d_shift_b", i), o.sb, e.sb);
        chk($sformatf("pair%0d_shift_res", i), o.sr, e.sr);
        chk($sformatf("pair%0d_clear", i), o.clr, e.clr);
        chk($sformatf("pair%0d_cycles", i), o.cyc, e.cyc);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl[8];
  logic [15:0] ra, rb;

  initial begin
    int t, w0, d0;

    tbl[0] = '{16'h8000, 16'h0001, 0, 8, 8, 0, 24};
    tbl[1] = '{16'h0300, 16'h0C00, 6, 4, 6, 0, 24};
    tbl[2] = '{16'hFFFF, 16'h4000, 0, 1, 15, 0, 24};
    tbl[3] = '{16'h00FF, 16'h0100, 8, 7, 1, 0, 24};
    tbl[4] = SKIP ? '{16'h0000, 16'h1234, 0, 0, 0, 1, 5}
                  : '{16'h0000, 16'h1234, 8, 3, 5, 0, 24};
    tbl[5] = SKIP ? '{16'h0000, 16'h0000, 0, 0, 0, 1, 5}
                  : '{16'h0000, 16'h0000, 8, 8, 0, 0, 24};
    tbl[6] = '{16'h0080, 16'h8001, 8, 0, 8, 0, 24};
    tbl[7] = '{16'h0001, 16'h0002, 8, 8, 0, 0, 24};

    // Reset state of both instances.
    repeat (3) tick();
    chk("reset_outputs_dut", outs1(), 0);
    chk("reset_outputs_dut2", outs2(), 0);
    rst = 1'b0;
    tick();
    chk("idle_outputs_dut", outs1(), 0);

    // Table-driven runs; first one holds start high for 10 cycles.
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < DEP; p++) begin
        mem[2*p]     = tbl[4*r+p].a;
        mem[2*p+1]   = tbl[4*r+p].b;
        exp_q.push_back('{addr: p, sa: tbl[4*r+p].sa, sb: tbl[4*r+p].sb,
                          sr: tbl[4*r+p].sr, clr: tbl[4*r+p].clr,
                          cyc: tbl[4*r+p].cyc});
      end
      run1((r == 0) ? 10 : 1);
    end

    // Randomised runs against the reference model.
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < DEP; p++) begin
        ra = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
        rb = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
        mem[2*p]   = ra;
        mem[2*p+1] = rb;
        exp_q.push_back(model(p, ra, rb));
      end
      run1($urandom_range(1, 3));
    end

    // KEEP_W == DATA_W instance: no shifts, 8 cycles per pair.
    for (int i = 0; i < 4; i++) mem2[i] = 8'($urandom_range(1, 255));
    w0 = obs2_cyc.size();
    d0 = done2_cnt;
    t  = sh2_cnt;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 200 && done2_cnt == d0; i++) tick();
    chk("dut2_done", done2_cnt - d0, 1);
    chk("dut2_no_shifts", sh2_cnt - t, 0);
    chk("dut2_writes", obs2_cyc.size() - w0, 2);
    for (int i = 0; i < 2; i++) begin
      if (w0 + i < obs2_cyc.size()) begin
        chk($sformatf("dut2_pair%0d_cycles", i), obs2_cyc[w0+i], 8);
        chk($sformatf("dut2_pair%0d_addr", i), obs2_addr[w0+i], i);
      end
    end

    // Reset while A is being normalised.
    mem[0] = 16'h0001;
    mem[1] = 16'h0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while (!shift_en_A && t < 20) begin
      tick();
      t++;
    end
    chk("reached_norm_a", int'(shift_en_A), 1);
    w0 = obs_q.size();
    rst = 1'b1;
    tick();
    chk("midrun_reset_outputs", outs1(), 0);
    rst = 1'b0;
    repeat (40) tick();
    chk("midrun_reset_no_write", obs_q.size() - w0, 0);
    chk("midrun_reset_idle", int'(busy), 0);

    // Recovery run after the mid-run reset.
    for (int p = 0; p < DEP; p++) begin
      ra = 16'($urandom_range(0, 65535) >> $urandom_range(0, 12));
      rb = 16'($urandom_range(0, 65535) >> $urandom_range(0, 12));
      mem[2*p]   = ra;
      mem[2*p+1] = rb;
      exp_q.push_back(model(p, ra, rb));
    end
    run1(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
